// File: rtl/bmp280_seq.sv
// BMP280 temperature sequencer: verifies chip ID, triggers a forced-mode conversion,
// polls the status register and publishes the 20-bit raw temperature on a fixed cadence.
module bmp280_seq #(
    parameter int         POLL_CYCLES = 1200000,
    parameter int         CONV_CYCLES = 120000,
    parameter int         TO_CYCLES   = 4096,
    parameter logic [7:0] CTRL_MEAS   = 8'h21
) (
    input  logic        clk12MHz,
    input  logic        rst_n,
    output logic        spi_go,
    output logic [15:0] spi_tx,
    input  logic        spi_done,
    input  logic [15:0] spi_rx,
    output logic [19:0] temp_raw,
    output logic        temp_valid,
    output logic        chip_ok,
    output logic        err
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_CYCLES);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

    typedef enum logic [3:0] {
        ID_REQ, ID_WAIT, WR_REQ, WR_WAIT, CONV, ST_REQ, ST_WAIT, MSB_REQ, MSB_WAIT,
        LSB_REQ, LSB_WAIT, XLSB_REQ, XLSB_WAIT, PUBLISH, POLL
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_spi_go;
    logic [15:0]   r_spi_tx;
    logic [19:0]   r_temp_raw;
    logic          r_temp_valid;
    logic          r_chip_ok;
    logic          r_err;
    logic [TW-1:0] r_to;
    logic [CW-1:0] r_conv;
    logic [PW-1:0] r_poll;
    logic [3:0]    r_retry;
    logic [7:0]    r_msb;
    logic [7:0]    r_lsb;
    logic [3:0]    r_xlsb;

    logic          w_go;
    logic [15:0]   w_tx;
    logic          w_is_wait;
    logic          w_to_hit;
    logic          w_id_match;
    logic          w_busy;
    logic          w_st_giveup;
    logic          w_err_set;
    logic          w_publish;
    logic          w_unused_rx;

    assign w_is_wait   = r_state inside {ID_WAIT, WR_WAIT, ST_WAIT, MSB_WAIT, LSB_WAIT, XLSB_WAIT};
    // A spi_done in the last allowed cycle takes priority over the timeout
    assign w_to_hit    = w_is_wait && !spi_done && (r_to == TO_LAST);
    assign w_id_match  = (spi_rx[7:0] == 8'h58);
    assign w_busy      = spi_rx[3];
    assign w_st_giveup = (r_state == ST_WAIT) && spi_done && w_busy && (r_retry == 4'hF);
    assign w_err_set   = w_to_hit || w_st_giveup ||
                         ((r_state == ID_WAIT) && spi_done && !w_id_match);
    assign w_publish   = (r_state == PUBLISH);
    assign w_unused_rx = ^spi_rx[15:8];

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) r_state <= ID_REQ;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ID_REQ:    w_next = ID_WAIT;
            ID_WAIT:   if (spi_done) w_next = w_id_match ? WR_REQ : POLL;
            WR_REQ:    w_next = WR_WAIT;
            WR_WAIT:   if (spi_done) w_next = CONV;
            CONV:      if (r_conv == CONV_LAST) w_next = ST_REQ;
            ST_REQ:    w_next = ST_WAIT;
            ST_WAIT:   if (spi_done) w_next = !w_busy ? MSB_REQ : (w_st_giveup ? POLL : ST_REQ);
            MSB_REQ:   w_next = MSB_WAIT;
            MSB_WAIT:  if (spi_done) w_next = LSB_REQ;
            LSB_REQ:   w_next = LSB_WAIT;
            LSB_WAIT:  if (spi_done) w_next = XLSB_REQ;
            XLSB_REQ:  w_next = XLSB_WAIT;
            XLSB_WAIT: if (spi_done) w_next = PUBLISH;
            PUBLISH:   w_next = POLL;
            POLL:      if (r_poll >= POLL_LAST) w_next = r_chip_ok ? WR_REQ : ID_REQ;
            default:   w_next = ID_REQ;
        endcase
        if (w_to_hit) w_next = POLL;
    end

    always_comb begin
        w_go = 1'b0;
        w_tx = r_spi_tx;
        case (r_state)
            ID_REQ:   begin w_go = 1'b1; w_tx = 16'hD000;          end
            WR_REQ:   begin w_go = 1'b1; w_tx = {8'h74, CTRL_MEAS}; end
            ST_REQ:   begin w_go = 1'b1; w_tx = 16'hF300;          end
            MSB_REQ:  begin w_go = 1'b1; w_tx = 16'hFA00;          end
            LSB_REQ:  begin w_go = 1'b1; w_tx = 16'hFB00;          end
            XLSB_REQ: begin w_go = 1'b1; w_tx = 16'hFC00;          end
            default:  ;
        endcase
    end

    // Outputs are registered, so each pulse appears in the cycle after its REQ/PUBLISH state
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_go     <= 1'b0;
            r_spi_tx     <= 16'h0000;
            r_temp_raw   <= 20'h00000;
            r_temp_valid <= 1'b0;
            r_chip_ok    <= 1'b0;
            r_err        <= 1'b0;
            r_to         <= '0;
            r_conv       <= '0;
            r_poll       <= '0;
            r_retry      <= 4'h0;
        end else begin
            r_spi_go     <= w_go;
            if (w_go) r_spi_tx <= w_tx;
            r_temp_valid <= w_publish;
            if (w_publish) r_temp_raw <= {r_msb, r_lsb, r_xlsb};
            if ((r_state == ID_WAIT) && spi_done) r_chip_ok <= w_id_match;
            else if (w_to_hit)                    r_chip_ok <= 1'b0;
            if (w_err_set) r_err <= 1'b1;
            r_to   <= w_is_wait ? r_to + 1'b1 : '0;
            r_conv <= (r_state == CONV) ? r_conv + 1'b1 : '0;
            // Poll counter holds cycles elapsed since the measurement-start REQ cycle
            if ((r_state == ID_REQ) || (r_state == WR_REQ)) r_poll <= PW'(1);
            else if (r_poll != POLL_MAX)                    r_poll <= r_poll + 1'b1;
            if (r_state == WR_REQ)                                 r_retry <= 4'h0;
            else if ((r_state == ST_WAIT) && spi_done && w_busy)   r_retry <= r_retry + 1'b1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if ((r_state == MSB_WAIT)  && spi_done) r_msb  <= spi_rx[7:0];
        if ((r_state == LSB_WAIT)  && spi_done) r_lsb  <= spi_rx[7:0];
        if ((r_state == XLSB_WAIT) && spi_done) r_xlsb <= spi_rx[7:4];
    end

    assign spi_go     = r_spi_go;
    assign spi_tx     = r_spi_tx;
    assign temp_raw   = r_temp_raw;
    assign temp_valid = r_temp_valid;
    assign chip_ok    = r_chip_ok;
    assign err        = r_err;

endmodule

// File: tb/tb_bmp280_seq.sv
// Directed bench for bmp280_seq with a behavioural BMP280/SPI responder.
module tb_bmp280_seq;

    localparam int POLL = 400;
    localparam int CONV = 20;
    localparam int TO   = 16;

    logic        clk12MHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rx   = 16'h0000;
    logic        spi_go;
    logic [15:0] spi_tx;
    logic [19:0] temp_raw;
    logic        temp_valid;
    logic        chip_ok;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0;
    logic [15:0] go_log[$];
    int          go_cyc[$];
    logic [7:0]  id_val    = 8'h58;
    int          st_busy_n = 0;
    int          st_reads  = 0;
    logic [15:0] spec_tx   = 16'h0000;
    int          spec_dly  = 2;

    bmp280_seq #(.POLL_CYCLES(POLL), .CONV_CYCLES(CONV), .TO_CYCLES(TO)) dut (
        .clk12MHz(clk12MHz), .rst_n(rst_n), .spi_go(spi_go), .spi_tx(spi_tx),
        .spi_done(spi_done), .spi_rx(spi_rx), .temp_raw(temp_raw),
        .temp_valid(temp_valid), .chip_ok(chip_ok), .err(err)
    );

    initial forever #5 clk12MHz = ~clk12MHz;
    initial forever begin @(posedge clk12MHz); cyc++; end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Responder: answers each spi_go with a done pulse 'pend' negedges later (0 = never)
    initial begin : spi_model
        int pend;
        logic [7:0] rb;
        pend = 0;
        rb = 8'h00;
        forever begin
            @(negedge clk12MHz);
            spi_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        spi_done = 1'b1;
                        spi_rx   = {8'hA5, rb};
                    end
                end
                if (spi_go) begin
                    go_log.push_back(spi_tx);
                    go_cyc.push_back(cyc);
                    case (spi_tx[15:8])
                        8'hD0:   rb = id_val;
                        8'hF3:   begin rb = (st_reads < st_busy_n) ? 8'h08 : 8'h00; st_reads++; end
                        8'hFA:   rb = 8'h12;
                        8'hFB:   rb = 8'h34;
                        8'hFC:   rb = 8'h56;
                        default: rb = 8'h00;
                    endcase
                    pend = (spi_tx == spec_tx) ? spec_dly : 2;
                end
                if (temp_valid) vcnt++;
            end
        end
    end

    task automatic do_reset(input logic [7:0] idv, input int busy);
        @(negedge clk12MHz);
        rst_n = 1'b0;
        id_val = idv; st_busy_n = busy; st_reads = 0;
        spec_tx = 16'h0000; spec_dly = 2;
        go_log.delete(); go_cyc.delete(); vcnt = 0;
        repeat (3) @(negedge clk12MHz);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk12MHz);
        total++; if (spi_go !== 1'b0)       begin bad++; $display("FAIL reset_go: got %b want 0", spi_go); end
        total++; if (spi_tx !== 16'h0000)   begin bad++; $display("FAIL reset_tx: got %h want 0000", spi_tx); end
        total++; if (temp_raw !== 20'h0)    begin bad++; $display("FAIL reset_raw: got %h want 00000", temp_raw); end
        total++; if (temp_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", temp_valid); end
        total++; if (chip_ok !== 1'b0)      begin bad++; $display("FAIL reset_chipok: got %b want 0", chip_ok); end
        total++; if (err !== 1'b0)          begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_normal();
        logic [15:0] exp_seq[6] = '{16'hD000, 16'h7421, 16'hF300, 16'hFA00, 16'hFB00, 16'hFC00};
        logic [15:0] got;
        int d;
        do_reset(8'h58, 0);
        @(negedge clk12MHz);
        total++; if (spi_go !== 1'b1 || spi_tx !== 16'hD000)
            begin bad++; $display("FAIL first_go: got go=%b tx=%h want go=1 tx=D000", spi_go, spi_tx); end
        for (int i = 0; i < 300 && vcnt == 0; i++) @(negedge clk12MHz);
        repeat (5) @(negedge clk12MHz);
        total++; if (vcnt !== 1)             begin bad++; $display("FAIL norm_valid_cnt: got %0d want 1", vcnt); end
        total++; if (temp_raw !== 20'h12345) begin bad++; $display("FAIL norm_raw: got %h want 12345", temp_raw); end
        total++; if (chip_ok !== 1'b1)       begin bad++; $display("FAIL norm_chipok: got %b want 1", chip_ok); end
        total++; if (err !== 1'b0)           begin bad++; $display("FAIL norm_err: got %b want 0", err); end
        total++; if (go_log.size() !== 6)    begin bad++; $display("FAIL norm_txn_cnt: got %0d want 6", go_log.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < go_log.size()) ? go_log[i] : 16'hDEAD;
            total++; if (got !== exp_seq[i]) begin bad++; $display("FAIL norm_seq[%0d]: got %h want %h", i, got, exp_seq[i]); end
        end
        for (int i = 0; i < POLL + 20 && go_log.size() < 7; i++) @(negedge clk12MHz);
        got = (go_log.size() > 6) ? go_log[6] : 16'hDEAD;
        d   = (go_cyc.size() > 6) ? go_cyc[6] - go_cyc[1] : -1;
        total++; if (got !== 16'h7421) begin bad++; $display("FAIL norm_next_start: got %h want 7421", got); end
        total++; if (d != POLL)        begin bad++; $display("FAIL norm_poll_period: got %0d want %0d", d, POLL); end
    endtask

    task automatic test_bad_id();
        int n74;
        int d;
        logic [15:0] got;
        do_reset(8'h60, 0);
        for (int i = 0; i < POLL + 20 && go_log.size() < 2; i++) @(negedge clk12MHz);
        repeat (5) @(negedge clk12MHz);
        n74 = 0;
        foreach (go_log[i]) if (go_log[i] == 16'h7421) n74++;
        got = (go_log.size() > 1) ? go_log[1] : 16'hDEAD;
        d   = (go_cyc.size() > 1) ? go_cyc[1] - go_cyc[0] : -1;
        total++; if (chip_ok !== 1'b0) begin bad++; $display("FAIL badid_chipok: got %b want 0", chip_ok); end
        total++; if (err !== 1'b1)     begin bad++; $display("FAIL badid_err: got %b want 1", err); end
        total++; if (n74 != 0)         begin bad++; $display("FAIL badid_no_write: got %0d writes want 0", n74); end
        total++; if (got !== 16'hD000) begin bad++; $display("FAIL badid_retry_tx: got %h want D000", got); end
        total++; if (d != POLL)        begin bad++; $display("FAIL badid_period: got %0d want %0d", d, POLL); end
    endtask

    task automatic test_status_retry();
        int nst;
        logic [15:0] got;
        do_reset(8'h58, 3);
        for (int i = 0; i < 300 && vcnt == 0; i++) @(negedge clk12MHz);
        nst = 0;
        foreach (go_log[i]) if (go_log[i] == 16'hF300) nst++;
        got = (go_log.size() > 6) ? go_log[6] : 16'hDEAD;
        total++; if (nst != 4)               begin bad++; $display("FAIL retry_st_cnt: got %0d want 4", nst); end
        total++; if (got !== 16'hFA00)       begin bad++; $display("FAIL retry_after_st: got %h want FA00", got); end
        total++; if (temp_raw !== 20'h12345) begin bad++; $display("FAIL retry_raw: got %h want 12345", temp_raw); end
        total++; if (err !== 1'b0)           begin bad++; $display("FAIL retry_err: got %b want 0", err); end
    endtask

    task automatic test_status_stuck();
        int nst;
        logic [15:0] got;
        do_reset(8'h58, 1000);
        repeat (200) @(negedge clk12MHz);
        nst = 0;
        foreach (go_log[i]) if (go_log[i] == 16'hF300) nst++;
        total++; if (nst != 16)           begin bad++; $display("FAIL stuck_st_cnt: got %0d want 16", nst); end
        total++; if (err !== 1'b1)        begin bad++; $display("FAIL stuck_err: got %b want 1", err); end
        total++; if (vcnt != 0)           begin bad++; $display("FAIL stuck_valid: got %0d want 0", vcnt); end
        total++; if (temp_raw !== 20'h0)  begin bad++; $display("FAIL stuck_raw: got %h want 00000", temp_raw); end
        for (int i = 0; i < POLL && go_log.size() < 19; i++) @(negedge clk12MHz);
        got = (go_log.size() > 18) ? go_log[18] : 16'hDEAD;
        total++; if (got !== 16'h7421)    begin bad++; $display("FAIL stuck_next_start: got %h want 7421", got); end
    endtask

    task automatic test_timeout();
        bit found;
        int n;
        logic [15:0] got;
        do_reset(8'h58, 0);
        for (int i = 0; i < 300 && vcnt == 0; i++) @(negedge clk12MHz);
        spec_tx = 16'hFB00; spec_dly = 0;
        found = 1'b0;
        for (int i = 0; i < POLL + 50; i++) begin
            @(negedge clk12MHz);
            if (spi_go && spi_tx == 16'hFB00) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL to_lsb_issued: got none want FB00"); end
        repeat (TO - 1) @(negedge clk12MHz);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_early: got err=%b want 0", err); end
        @(negedge clk12MHz);
        total++; if (err !== 1'b1)           begin bad++; $display("FAIL to_err: got %b want 1", err); end
        total++; if (chip_ok !== 1'b0)       begin bad++; $display("FAIL to_chipok: got %b want 0", chip_ok); end
        total++; if (temp_raw !== 20'h12345) begin bad++; $display("FAIL to_raw_kept: got %h want 12345", temp_raw); end
        total++; if (vcnt != 1)              begin bad++; $display("FAIL to_valid_cnt: got %0d want 1", vcnt); end
        n = go_log.size();
        for (int i = 0; i < POLL + 50 && go_log.size() == n; i++) @(negedge clk12MHz);
        got = (go_log.size() > n) ? go_log[n] : 16'hDEAD;
        total++; if (got !== 16'hD000) begin bad++; $display("FAIL to_restart: got %h want D000", got); end
    endtask

    task automatic test_exact_timeout();
        do_reset(8'h58, 0);
        spec_tx = 16'hFB00; spec_dly = TO - 1;
        for (int i = 0; i < 300 && vcnt == 0; i++) @(negedge clk12MHz);
        total++; if (vcnt != 1)              begin bad++; $display("FAIL edge_valid: got %0d want 1", vcnt); end
        total++; if (err !== 1'b0)           begin bad++; $display("FAIL edge_err: got %b want 0", err); end
        total++; if (temp_raw !== 20'h12345) begin bad++; $display("FAIL edge_raw: got %h want 12345", temp_raw); end
        total++; if (chip_ok !== 1'b1)       begin bad++; $display("FAIL edge_chipok: got %b want 1", chip_ok); end
    endtask

    task automatic test_async_reset();
        bit stray_go;
        do_reset(8'h58, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk12MHz);
            if (spi_go && spi_tx == 16'hFA00) break;
        end
        @(negedge clk12MHz);
        #2 rst_n = 1'b0;
        #1;
        total++; if (spi_go !== 1'b0)     begin bad++; $display("FAIL arst_go: got %b want 0", spi_go); end
        total++; if (spi_tx !== 16'h0000) begin bad++; $display("FAIL arst_tx: got %h want 0000", spi_tx); end
        total++; if (chip_ok !== 1'b0)    begin bad++; $display("FAIL arst_chipok: got %b want 0", chip_ok); end
        total++; if (temp_valid !== 1'b0 || temp_raw !== 20'h0 || err !== 1'b0)
            begin bad++; $display("FAIL arst_misc: got valid=%b raw=%h err=%b want 0/00000/0", temp_valid, temp_raw, err); end
        stray_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk12MHz);
            if (spi_go !== 1'b0) stray_go = 1'b1;
        end
        total++; if (stray_go) begin bad++; $display("FAIL arst_hold_go: got go during reset want none"); end
        rst_n = 1'b1;
        @(negedge clk12MHz);
        total++; if (spi_go !== 1'b1 || spi_tx !== 16'hD000)
            begin bad++; $display("FAIL arst_restart: got go=%b tx=%h want go=1 tx=D000", spi_go, spi_tx); end
        for (int i = 0; i < 300 && vcnt == 0; i++) @(negedge clk12MHz);
        total++; if (vcnt != 1 || temp_raw !== 20'h12345)
            begin bad++; $display("FAIL arst_publish: got cnt=%0d raw=%h want 1/12345", vcnt, temp_raw); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_id();
        test_status_retry();
        test_status_stuck();
        test_timeout();
        test_exact_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bmp280_seq.md
BMP280_SEQ -- requirements
Module: bmp280_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter POLL_CYCLES, default 1200000, meaning clk12MHz cycles from one measurement start to the next (100 ms).
REQ-002 The block SHALL have parameter CONV_CYCLES, default 120000, meaning the wait in cycles after the ctrl_meas write before the first status read.
REQ-003 The block SHALL have parameter TO_CYCLES, default 4096, meaning the per-transaction spi_done timeout in cycles.
REQ-004 The block SHALL have parameter CTRL_MEAS, default 8'h21, meaning the ctrl_meas value written (osrs_t x1, forced mode).
Ports:
REQ-005 The block SHALL have port clk12MHz, input, 1 bit: system clock; everything is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port spi_go, output, 1 bit: one-cycle pulse that starts a 16-bit SPI transaction.
REQ-008 The block SHALL have port spi_tx, output, 16 bits: transaction word, with the address/RW byte in [15:8] and the data byte in [7:0].
REQ-009 The block SHALL have port spi_done, input, 1 bit: one-cycle pulse marking transaction completion.
REQ-010 The block SHALL have port spi_rx, input, 16 bits: received word, valid only in the spi_done cycle, with the register byte in [7:0].
REQ-011 The block SHALL have port temp_raw, output, 20 bits: last raw temperature.
REQ-012 The block SHALL have port temp_valid, output, 1 bit: one-cycle pulse when temp_raw updates.
REQ-013 The block SHALL have port chip_ok, output, 1 bit: the last chip-ID read returned 8'h58.
REQ-014 The block SHALL have port err, output, 1 bit: sticky error flag, cleared only by reset.

Function
REQ-015 The state machine SHALL have these states: ID_REQ, ID_WAIT, WR_REQ, WR_WAIT, CONV, ST_REQ, ST_WAIT, MSB_REQ, MSB_WAIT, LSB_REQ, LSB_WAIT, XLSB_REQ, XLSB_WAIT, PUBLISH, POLL.
REQ-016 Every *_REQ state SHALL last exactly one cycle, drive spi_go=1, drive spi_tx, and advance to its *_WAIT state.
REQ-017 spi_tx SHALL hold its value from the REQ cycle until the matching spi_done.
REQ-018 spi_tx SHALL take these values:
  - ID: 16'hD000
  - WR: {8'h74, CTRL_MEAS}
  - ST: 16'hF300
  - MSB: 16'hFA00
  - LSB: 16'hFB00
  - XLSB: 16'hFC00
REQ-019 Each *_WAIT state SHALL advance on the first spi_done and capture spi_rx[7:0] in that same cycle.
REQ-020 spi_done SHALL be ignored in any state other than a *_WAIT state, including the REQ cycle itself.
REQ-021 ID_WAIT SHALL set chip_ok to (spi_rx[7:0]==8'h58).
REQ-022 On a chip-ID match, ID_WAIT SHALL go to WR_REQ.
REQ-023 On a chip-ID mismatch, ID_WAIT SHALL set err and go to POLL, and the next measurement start SHALL return to ID_REQ.
REQ-024 WR_WAIT SHALL go to CONV.
REQ-025 CONV SHALL count CONV_CYCLES cycles, then go to ST_REQ.
REQ-026 In ST_WAIT, if spi_rx[3]==1 (measuring), the block SHALL return to ST_REQ and increment a 4-bit retry counter.
REQ-027 If spi_rx[3]==1 on the 16th status read, the block SHALL set err and go to POLL without publishing.
REQ-028 In ST_WAIT, if spi_rx[3]==0, the block SHALL go to MSB_REQ.
REQ-029 MSB_WAIT SHALL go to LSB_REQ, LSB_WAIT SHALL go to XLSB_REQ, and XLSB_WAIT SHALL go to PUBLISH.
REQ-030 PUBLISH SHALL last one cycle, load temp_raw={msb, lsb, xlsb[7:4]}, pulse temp_valid, and go to POLL.
REQ-031 temp_valid SHALL be high only in the cycle after PUBLISH is entered, i.e. it is registered and concurrent with the new temp_raw.
REQ-032 POLL SHALL wait until POLL_CYCLES cycles have elapsed since the last WR_REQ (or since the ID_REQ after reset/ID failure), then go to WR_REQ if chip_ok=1, else to ID_REQ.
REQ-033 The poll counter SHALL saturate and never wrap.
REQ-034 The transaction timeout counter SHALL clear in every REQ cycle and count in every WAIT cycle.
REQ-035 When the timeout counter reaches TO_CYCLES without spi_done, the block SHALL set err, clear chip_ok, and go to POLL.
REQ-036 A spi_done arriving in the same cycle as the timeout SHALL win, with no error recorded.
REQ-037 temp_raw SHALL retain its previous value on any error path.

Reset
REQ-038 While rst_n=0, the outputs SHALL be: spi_go=0, spi_tx=16'h0000, temp_raw=0, temp_valid=0, chip_ok=0, err=0.
REQ-039 While rst_n=0, the state SHALL be ID_REQ and all counters SHALL be 0.
REQ-040 Assertion of rst_n mid-transaction SHALL abort immediately, with no spi_go pulse until reset is released.
REQ-041 The first spi_go after reset release SHALL occur in the first clock edge after deassertion, with spi_tx=16'hD000.

Verification
REQ-042 The bench SHALL cover: reset release with an SPI model returning 58 for D0, 00 for F3, and 12/34/56 for FA/FB/FC -> spi_go sequence D000, 7421, F300, FA00, FB00, FC00; then temp_valid pulses once with temp_raw=20'h12345; chip_ok=1; err=0.
REQ-043 The bench SHALL cover: chip ID returns 8'h60 -> chip_ok=0, err=1, no 7421 issued, and ID_REQ repeated POLL_CYCLES after the first.
REQ-044 The bench SHALL cover: status returns 08 three times then 00 -> exactly 4 F300 transactions, then a normal publish.
REQ-045 The bench SHALL cover: status always 08 -> 16 F300 transactions, err=1, no temp_valid, next cycle starts at 7421.
REQ-046 The bench SHALL cover: spi_done withheld in LSB_WAIT -> err=1 after TO_CYCLES cycles, chip_ok=0, temp_raw unchanged; and separately spi_done in the exact timeout cycle -> no err.
REQ-047 The bench SHALL cover: rst_n pulsed low mid MSB_WAIT -> all outputs return to reset values asynchronously, followed by a clean restart at D000.
